// File: rtl/bool_sweep_pkg.sv
// Shared types and widths for the boolean-unit truth-table sweeper.
package bool_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned VEC_W       = 4;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned SET_W       = 8;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/bool_sweep_ctrl_if.sv
// Harness/unit-facing signal bundle of the sweeper; slave is the sweeper side.
interface bool_sweep_ctrl_if;
  import bool_sweep_pkg::*;

  logic                   start;
  logic                   abort;
  logic [NUM_VECTORS-1:0] expected;
  logic                   y_in;
  logic [VEC_W-1:0]       abcd;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] truth_table;
  logic                   match;
  logic [CNT_W-1:0]       mismatch_count;
  logic [VEC_W-1:0]       first_fail;

  modport master (
    output start, abort, expected, y_in,
    input  abcd, busy, done, truth_table, match, mismatch_count, first_fail
  );

  modport slave (
    input  start, abort, expected, y_in,
    output abcd, busy, done, truth_table, match, mismatch_count, first_fail
  );

endinterface

// File: rtl/bool_sweep_ctrl.sv
// Steps a 4-input boolean unit through all 16 minterms, samples Y after a
// settle hold per vector, and compares the captured truth table to a reference.
module bool_sweep_ctrl
  import bool_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  bool_sweep_ctrl_if.slave  bus
);

  localparam logic [SET_W-1:0] LAST_CNT = SET_W'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SET_W-1:0]       cnt_q,   cnt_d;
  logic [VEC_W-1:0]       abcd_q,  abcd_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;
  logic [NUM_VECTORS-1:0] tt_q,    tt_d;
  logic                   match_q, match_d;
  logic [CNT_W-1:0]       mmc_q,   mmc_d;
  logic [VEC_W-1:0]       ff_q,    ff_d;
  logic [NUM_VECTORS-1:0] exp_q,   exp_d;
  logic                   miss_c;

  assign miss_c = (bus.y_in != exp_q[abcd_q]);

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      mmc_q   <= '0;
      ff_q    <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      mmc_q   <= mmc_d;
      ff_q    <= ff_d;
      exp_q   <= exp_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    match_d = match_q;
    mmc_d   = mmc_q;
    ff_d    = ff_q;
    exp_d   = exp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d   = bus.expected;
          tt_d    = '0;
          mmc_d   = '0;
          ff_d    = '0;
          match_d = 1'b0;
          abcd_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          // Abort wins over a coincident sample; partial results stay visible.
          state_d = IDLE;
          abcd_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          match_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          tt_d[abcd_q] = bus.y_in;
          if (miss_c) begin
            mmc_d = mmc_q + CNT_W'(1);
            if (mmc_q == '0) begin
              ff_d = abcd_q;
            end
          end
          cnt_d = '0;
          if (abcd_q == LAST_VEC) begin
            state_d = FINISH;
            done_d  = 1'b1;
            match_d = (mmc_d == '0);
          end else begin
            abcd_d = abcd_q + VEC_W'(1);
          end
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
        abcd_d  = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        if (bus.abort) begin
          match_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        abcd_d  = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.abcd           = abcd_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.truth_table    = tt_q;
  assign bus.match          = match_q;
  assign bus.mismatch_count = mmc_q;
  assign bus.first_fail     = ff_q;

endmodule
